// File: rtl/dma_slot_sequencer_if.sv
// Control/handshake bundle between the bank0/bank1 register side, the AXI-Lite
// write master and the slot sequencer.
interface dma_slot_sequencer_if #(
  parameter int BANK1_INDEX_WIDTH   = 2,
  parameter int BANK1_STATUS_WIDTH  = 2,
  parameter int BANK1_PROFILE_WIDTH = 32,
  parameter int DMA_INIT_TASK_CNT   = 6
);
  logic                           ctrl_start;
  logic                           ctrl_stop;
  logic [BANK1_INDEX_WIDTH-1:0]   ctrl_last_slot;
  logic                           dma_done;
  logic [DMA_INIT_TASK_CNT-1:0]   slaveInit;
  logic [DMA_INIT_TASK_CNT-1:0]   slaveFinInit;
  logic [BANK1_INDEX_WIDTH-1:0]   cur_slot;
  logic                           slot_wr_en;
  logic [BANK1_STATUS_WIDTH-1:0]  slot_wr_status;
  logic [BANK1_PROFILE_WIDTH-1:0] slot_wr_profile;
  logic                           seq_busy;
  logic                           seq_done;

  // Sequencer side.
  modport master (
    input  ctrl_start, ctrl_stop, ctrl_last_slot, dma_done, slaveFinInit,
    output slaveInit, cur_slot, slot_wr_en, slot_wr_status, slot_wr_profile,
           seq_busy, seq_done
  );

  // Register file / write master side.
  modport slave (
    output ctrl_start, ctrl_stop, ctrl_last_slot, dma_done, slaveFinInit,
    input  slaveInit, cur_slot, slot_wr_en, slot_wr_status, slot_wr_profile,
           seq_busy, seq_done
  );
endinterface

// File: rtl/dma_slot_sequencer.sv
// Walks bank1 slots 0..last: issues the six DMA-init write tasks one-hot, waits
// for S2MM completion, then writes status and cycle profile back to the slot.
module dma_slot_sequencer #(
  parameter int BANK1_INDEX_WIDTH   = 2,
  parameter int BANK1_STATUS_WIDTH  = 2,
  parameter int BANK1_PROFILE_WIDTH = 32,
  parameter int DMA_INIT_TASK_CNT   = 6,
  parameter int DONE_TIMEOUT        = 1000000
) (
  input logic                  clk,
  input logic                  reset,
  dma_slot_sequencer_if.master bus
);

  localparam int TO_WIDTH = ($clog2(DONE_TIMEOUT) > 0) ? $clog2(DONE_TIMEOUT) : 1;
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(DONE_TIMEOUT - 1);

  // S2MM tasks (bits 3..5) go out before MM2S (bits 0..2): rotate left from bit 3.
  localparam logic [DMA_INIT_TASK_CNT-1:0] FIRST_TASK = DMA_INIT_TASK_CNT'(1) << 3;
  localparam logic [DMA_INIT_TASK_CNT-1:0] LAST_TASK  = DMA_INIT_TASK_CNT'(1) << 2;

  localparam logic [BANK1_STATUS_WIDTH-1:0] ST_OK      = BANK1_STATUS_WIDTH'(2'b10);
  localparam logic [BANK1_STATUS_WIDTH-1:0] ST_TIMEOUT = BANK1_STATUS_WIDTH'(2'b11);
  localparam logic [BANK1_STATUS_WIDTH-1:0] ST_ABORT   = BANK1_STATUS_WIDTH'(2'b01);

  typedef enum logic [2:0] {IDLE, INIT, WAIT_DMA, WRITEBACK, NEXT} state_t;

  state_t                         state;
  logic [BANK1_INDEX_WIDTH-1:0]   last_slot;
  logic                           stop_pending;
  logic                           aborted;
  logic [BANK1_PROFILE_WIDTH-1:0] prof;
  logic [TO_WIDTH-1:0]            to_cnt;

  logic [BANK1_PROFILE_WIDTH-1:0] prof_inc;
  logic [DMA_INIT_TASK_CNT-1:0]   task_next;
  logic                           fin_hit;
  logic                           last_reached;

  assign prof_inc     = (&prof) ? prof : prof + BANK1_PROFILE_WIDTH'(1);
  assign task_next    = {bus.slaveInit[DMA_INIT_TASK_CNT-2:0], bus.slaveInit[DMA_INIT_TASK_CNT-1]};
  assign fin_hit      = (bus.slaveInit != '0) && (bus.slaveFinInit == bus.slaveInit);
  assign last_reached = (bus.cur_slot == last_slot);

  // NOTE: every output is a register cleared by the async reset, so slaveInit
  // drops the moment reset asserts instead of waiting for a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state               <= IDLE;
      last_slot           <= '0;
      stop_pending        <= 1'b0;
      aborted             <= 1'b0;
      prof                <= '0;
      to_cnt              <= '0;
      bus.slaveInit       <= '0;
      bus.cur_slot        <= '0;
      bus.slot_wr_en      <= 1'b0;
      bus.slot_wr_status  <= '0;
      bus.slot_wr_profile <= '0;
      bus.seq_busy        <= 1'b0;
      bus.seq_done        <= 1'b0;
    end else begin
      // NOTE: strobes default low each cycle; only the branches below raise them.
      bus.slot_wr_en <= 1'b0;
      bus.seq_done   <= 1'b0;

      unique case (state)
        IDLE: begin
          if (bus.ctrl_start) begin
            last_slot     <= bus.ctrl_last_slot;
            stop_pending  <= bus.ctrl_stop;
            aborted       <= 1'b0;
            prof          <= '0;
            bus.cur_slot  <= '0;
            bus.slaveInit <= FIRST_TASK;
            bus.seq_busy  <= 1'b1;
            state         <= INIT;
          end
        end

        INIT: begin
          prof <= prof_inc;
          if (bus.ctrl_stop) stop_pending <= 1'b1;
          // An issued write is never withdrawn; stop only takes effect at its fin.
          if (fin_hit) begin
            if (stop_pending || bus.ctrl_stop) begin
              bus.slaveInit       <= '0;
              aborted             <= 1'b1;
              bus.slot_wr_en      <= 1'b1;
              bus.slot_wr_status  <= ST_ABORT;
              bus.slot_wr_profile <= prof_inc;
              state               <= WRITEBACK;
            end else if (bus.slaveInit == LAST_TASK) begin
              bus.slaveInit <= '0;
              to_cnt        <= '0;
              state         <= WAIT_DMA;
            end else begin
              bus.slaveInit <= task_next;
            end
          end
        end

        WAIT_DMA: begin
          prof <= prof_inc;
          if (bus.dma_done || bus.ctrl_stop || (to_cnt == TO_LAST)) begin
            bus.slot_wr_en      <= 1'b1;
            bus.slot_wr_profile <= prof_inc;
            state               <= WRITEBACK;
            if (bus.dma_done) begin
              bus.slot_wr_status <= ST_OK;
            end else if (bus.ctrl_stop) begin
              bus.slot_wr_status <= ST_ABORT;
              aborted            <= 1'b1;
            end else begin
              bus.slot_wr_status <= ST_TIMEOUT;
            end
          end else begin
            to_cnt <= to_cnt + TO_WIDTH'(1);
          end
        end

        WRITEBACK: begin
          if (aborted || bus.ctrl_stop || last_reached) bus.seq_done <= 1'b1;
          if (bus.ctrl_stop) aborted <= 1'b1;
          state <= NEXT;
        end

        NEXT: begin
          if (aborted || last_reached) begin
            bus.seq_busy <= 1'b0;
            state        <= IDLE;
          end else begin
            bus.cur_slot  <= bus.cur_slot + BANK1_INDEX_WIDTH'(1);
            prof          <= '0;
            stop_pending  <= 1'b0;
            bus.slaveInit <= FIRST_TASK;
            state         <= INIT;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_slot_sequencer.sv
// Scoreboard bench for dma_slot_sequencer with a write-master model (fin 3 cycles
// after each request) and a DMA model (done 10 cycles after the last init fin).
module tb_dma_slot_sequencer;

  localparam int IW = 2, SW = 2, PW = 32, TC = 6, TO = 16;
  localparam int FIN_LAT = 3, DMA_LAT = 10;
  localparam int INIT_CYC = TC * (FIN_LAT + 1);
  localparam logic [PW-1:0] PROF_OK = PW'(INIT_CYC + DMA_LAT);
  localparam logic [PW-1:0] PROF_TO = PW'(INIT_CYC + TO);

  logic clk = 1'b0;
  logic reset = 1'b0;

  dma_slot_sequencer_if #(
    .BANK1_INDEX_WIDTH(IW), .BANK1_STATUS_WIDTH(SW),
    .BANK1_PROFILE_WIDTH(PW), .DMA_INIT_TASK_CNT(TC)
  ) bus ();

  dma_slot_sequencer #(
    .BANK1_INDEX_WIDTH(IW), .BANK1_STATUS_WIDTH(SW),
    .BANK1_PROFILE_WIDTH(PW), .DMA_INIT_TASK_CNT(TC), .DONE_TIMEOUT(TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct { logic [IW-1:0] slot; logic [TC-1:0] tsk; } init_exp_t;
  typedef struct { logic [IW-1:0] slot; logic [SW-1:0] status; logic [PW-1:0] profile; } wb_exp_t;

  init_exp_t      init_q[$];
  wb_exp_t        wb_q[$];
  logic [IW-1:0]  done_q[$];
  logic [TC-1:0]  task_order [TC] = '{6'b001000, 6'b010000, 6'b100000,
                                      6'b000001, 6'b000010, 6'b000100};

  int n_vec = 0;
  int n_miss = 0;
  int done_cnt = 0;
  logic [TC-1:0] inject_fin = '0;
  bit            dma_en = 1'b1;
  logic [TC-1:0] prev_init = '0;
  logic [TC-1:0] prev_fin = '0;
  logic          prev_wr_en = 1'b0;
  init_exp_t     ie;
  wb_exp_t       we;
  logic [IW-1:0] de;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write master + DMA model.
  initial begin : env_model
    int age;
    int dma_cnt;
    age = 0;
    dma_cnt = 0;
    bus.slaveFinInit = '0;
    bus.dma_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.slaveFinInit = inject_fin;
      bus.dma_done = 1'b0;
      if (!reset) begin
        age = 0;
        dma_cnt = 0;
      end else begin
        if (dma_cnt > 0) begin
          dma_cnt--;
          if (dma_cnt == 0) bus.dma_done = dma_en;
        end
        if (bus.slaveInit == '0) begin
          age = 0;
        end else begin
          age++;
          if (age == FIN_LAT + 1) begin
            bus.slaveFinInit = bus.slaveInit;
            age = 0;
            if (bus.slaveInit == 6'b000100) dma_cnt = DMA_LAT;
          end
        end
      end
    end
  end

  // Output monitor: pops the scoreboard whenever the DUT produces an event.
  always @(negedge clk) begin
    if (!reset) begin
      prev_init  = '0;
      prev_fin   = '0;
      prev_wr_en = 1'b0;
    end else begin
      if (bus.slaveInit != prev_init && prev_init != '0)
        check("init_held_until_fin", prev_fin, prev_init);
      if (bus.slaveInit != prev_init && bus.slaveInit != '0) begin
        check("init_onehot", $onehot(bus.slaveInit), 1);
        check("init_queued", init_q.size() > 0, 1);
        if (init_q.size() > 0) begin
          ie = init_q.pop_front();
          check("init_task", bus.slaveInit, ie.tsk);
          check("init_slot", bus.cur_slot, ie.slot);
        end
      end
      if (bus.slot_wr_en) begin
        check("wb_queued", wb_q.size() > 0, 1);
        check("wb_no_done", bus.seq_done, 0);
        if (wb_q.size() > 0) begin
          we = wb_q.pop_front();
          check("wb_slot", bus.cur_slot, we.slot);
          check("wb_status", bus.slot_wr_status, we.status);
          check("wb_profile", bus.slot_wr_profile, we.profile);
        end
      end
      if (bus.seq_done) begin
        check("done_after_wb", prev_wr_en, 1);
        check("done_queued", done_q.size() > 0, 1);
        if (done_q.size() > 0) begin
          de = done_q.pop_front();
          check("done_slot", bus.cur_slot, de);
        end
        done_cnt++;
      end
      prev_init  = bus.slaveInit;
      prev_fin   = bus.slaveFinInit;
      prev_wr_en = bus.slot_wr_en;
    end
  end

  task automatic expect_run(input int last, input bit ok);
    for (int s = 0; s <= last; s++) begin
      for (int k = 0; k < TC; k++) init_q.push_back('{slot: IW'(s), tsk: task_order[k]});
      wb_q.push_back('{slot: IW'(s), status: ok ? 2'b10 : 2'b11, profile: ok ? PROF_OK : PROF_TO});
    end
    done_q.push_back(IW'(last));
  endtask

  task automatic start(input int last);
    bus.ctrl_start = 1'b1;
    bus.ctrl_last_slot = IW'(last);
    @(negedge clk);
    bus.ctrl_start = 1'b0;
  endtask

  task automatic wait_init(input logic [TC-1:0] val, input int budget);
    int n;
    n = 0;
    while (bus.slaveInit != val && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_init", bus.slaveInit, val);
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("seq_done_count", done_cnt, target);
    repeat (3) @(negedge clk);
    check("idle_busy", bus.seq_busy, 0);
    check("idle_init", bus.slaveInit, 0);
    check("init_q_left", init_q.size(), 0);
    check("wb_q_left", wb_q.size(), 0);
    check("done_q_left", done_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_slaveInit"}, bus.slaveInit, 0);
    check({tag, "_cur_slot"}, bus.cur_slot, 0);
    check({tag, "_wr_en"}, bus.slot_wr_en, 0);
    check({tag, "_wr_status"}, bus.slot_wr_status, 0);
    check({tag, "_wr_profile"}, bus.slot_wr_profile, 0);
    check({tag, "_busy"}, bus.seq_busy, 0);
    check({tag, "_done"}, bus.seq_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ctrl_start = 1'b0;
    bus.ctrl_stop = 1'b0;
    bus.ctrl_last_slot = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    // Single slot, normal completion.
    expect_run(0, 1'b1);
    start(0);
    wait_done(1, 200);

    // Four slots.
    expect_run(3, 1'b1);
    start(3);
    wait_done(2, 600);

    // DMA never completes: timeout.
    dma_en = 1'b0;
    expect_run(0, 1'b0);
    start(0);
    wait_done(3, 200);
    dma_en = 1'b1;

    // Stop during the second task: task held to its fin, then aborted writeback.
    init_q.push_back('{slot: '0, tsk: 6'b001000});
    init_q.push_back('{slot: '0, tsk: 6'b010000});
    wb_q.push_back('{slot: '0, status: 2'b01, profile: PW'(2 * (FIN_LAT + 1))});
    done_q.push_back('0);
    start(0);
    wait_init(6'b010000, 50);
    bus.ctrl_stop = 1'b1;
    repeat (2) @(negedge clk);
    bus.ctrl_stop = 1'b0;
    wait_done(4, 100);

    // Reset while the third task is outstanding.
    expect_run(0, 1'b1);
    start(0);
    wait_init(6'b100000, 50);
    #2 reset = 1'b0;
    #1 check_all_zero("async_rst");
    init_q.delete();
    wb_q.delete();
    done_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_busy", bus.seq_busy, 0);
    expect_run(0, 1'b1);
    start(0);
    wait_done(5, 200);

    // Spurious fin and start-while-busy are both ignored.
    expect_run(0, 1'b1);
    start(0);
    wait_init(6'b001000, 10);
    inject_fin = 6'b000001;
    bus.ctrl_start = 1'b1;
    bus.ctrl_last_slot = 2'd3;
    @(negedge clk);
    inject_fin = '0;
    bus.ctrl_start = 1'b0;
    bus.ctrl_last_slot = '0;
    wait_done(6, 200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/dma_slot_sequencer.md
Name: dma_slot_sequencer

Overview:
- Upstream control stage that feeds m_axi_write. Walks bank1 slots 0..ctrl_last_slot in order.
- For each slot it issues the six DMA-init write tasks as one-hot requests on slaveInit. It then waits for DMA completion and writes status and cycle-count profile back to the bank1 slot.
- Sits between the bank0 control register and the AXI-Lite write master.

Parameters:
- BANK1_INDEX_WIDTH, 2, slot index width (4 slots).
- BANK1_STATUS_WIDTH, 2, slot status width.
- BANK1_PROFILE_WIDTH, 32, profile counter width.
- DMA_INIT_TASK_CNT, 6, number of init tasks; one-hot width of slaveInit.
- DONE_TIMEOUT, 1000000, cycles allowed in WAIT_DMA before a slot is flagged as timed out.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- ctrl_start  in  1  one-cycle start pulse from bank0; ignored unless IDLE
- ctrl_stop  in  1  abort request, level
- ctrl_last_slot  in  BANK1_INDEX_WIDTH  last slot index to run; sampled on start
- dma_done  in  1  DMA S2MM completion, level; acted on only in WAIT_DMA
- slaveInit  out  DMA_INIT_TASK_CNT  one-hot init-task request to the write master
- slaveFinInit  in  DMA_INIT_TASK_CNT  one-cycle completion pulse, equal to slaveInit
- cur_slot  out  BANK1_INDEX_WIDTH  slot index driving the bank1 read mux
- slot_wr_en  out  1  one-cycle bank1 write strobe for cur_slot
- slot_wr_status  out  BANK1_STATUS_WIDTH  status to write: 2'b10 ok, 2'b11 timeout, 2'b01 aborted
- slot_wr_profile  out  BANK1_PROFILE_WIDTH  cycles from first init issue to done, or to abort/timeout
- seq_busy  out  1  high in any state other than IDLE
- seq_done  out  1  one-cycle pulse when the last slot is written back or an abort completes

Behaviour:
- Reset (async, active-low): state=IDLE. slaveInit, cur_slot, slot_wr_en, slot_wr_status, slot_wr_profile, seq_busy, seq_done, profile counter and timeout counter all =0. Asserting reset mid-operation drops slaveInit to 0 immediately.
- States: IDLE, INIT, WAIT_DMA, WRITEBACK, NEXT.
- IDLE, ctrl_start=1: latch ctrl_last_slot; cur_slot=0; go INIT.
  - slaveInit=6'b001000 next cycle (destination channel first).
  - Clear the profile counter.
- INIT:
  - Task order is 6'b001000 -> 010000 -> 100000 -> 000001 -> 000010 -> 000100 (S2MM armed before MM2S).
  - slaveInit is held stable and exactly one-hot until slaveFinInit==slaveInit.
  - On that edge, load the next one-hot; the write master sees the new request on its next IDLE cycle.
  - Fin after the 6th task: slaveInit=0, go WAIT_DMA.
  - slaveFinInit not equal to the current slaveInit (including zero) is ignored.
- WAIT_DMA:
  - dma_done=1: go WRITEBACK with status 2'b10.
  - Timeout counter reaches DONE_TIMEOUT-1: go WRITEBACK with status 2'b11.
  - dma_done and timeout in the same cycle: done wins.
  - The timeout counter clears on entry.
- Profile counter:
  - Increments every cycle in INIT and WAIT_DMA.
  - Saturates at all-ones and does not wrap.
  - slot_wr_profile = counter value at the exit edge.
- WRITEBACK:
  - slot_wr_en=1 for exactly one cycle, with status and profile valid.
  - cur_slot is unchanged during this cycle.
  - Then go NEXT.
- NEXT:
  - cur_slot==last: pulse seq_done, go IDLE.
  - Otherwise cur_slot+1, clear profile, go INIT with slaveInit=6'b001000.
- cur_slot is held constant from INIT entry to NEXT, so the bank1 data seen by the write master is stable.
- ctrl_stop:
  - INIT: an issued AXI write is never withdrawn. Hold slaveInit until its fin, then go WRITEBACK with status 2'b01 and issue no further tasks.
  - WAIT_DMA: go WRITEBACK with status 2'b01 next cycle.
  - After an aborted writeback: pulse seq_done, go IDLE.
  - ctrl_stop in IDLE has no effect.
  - ctrl_stop and ctrl_start together in IDLE: start is honoured, then INIT aborts after the first task's fin.
- ctrl_start while busy is ignored.
- seq_done and slot_wr_en never coincide. seq_done follows the final writeback by 1 cycle.

Test Plan:
- Single slot (last=0); write-master model returns fin 3 cycles after each request; dma_done 10 cycles after the 6th fin -> slaveInit sequence 08,10,20,01,02,04, each held until fin. One slot_wr_en with status 2'b10 and profile equal to the counted cycles. seq_done 1 cycle later.
- last=3 -> cur_slot steps 0,1,2,3; 24 init tasks; 4 writebacks; exactly one seq_done, after slot 3.
- DONE_TIMEOUT=16, dma_done never asserted -> writeback status 2'b11, profile = INIT cycles + 16.
- ctrl_stop during the 2nd task (slaveInit=10) -> slaveInit held until its fin and no 3rd task issued. Writeback status 2'b01, then seq_done, then IDLE.
- Reset asserted while slaveInit=20 -> all outputs 0 asynchronously. After release, IDLE; start works normally.
- Spurious slaveFinInit=6'b000001 while slaveInit=08, plus ctrl_start while busy -> both ignored; sequence unchanged.
